// File: rtl/axi_sram_slave.sv
// Single-beat AXI responder in front of a synchronous single-port SRAM.
// AW/W/B/AR/R target; one FSM serialises accesses; SLVERR on bad wlast/address.
module axi_sram_slave #(
  parameter int SRAM_AW = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        awaddr,
  input  logic               awvalid,
  output logic               awready,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  input  logic [31:0]        araddr,
  input  logic               arvalid,
  output logic               arready,
  output logic [31:0]        rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR, BRESP, RD, RCAP, RRESP
  } state_t;

  state_t state;

  logic               aw_held;
  logic               w_held;
  logic [SRAM_AW-1:0] aw_word;
  logic               aw_oor;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               wlast_q;
  logic               ar_err;

  logic               idle;
  logic               aw_hs;
  logic               w_hs;
  logic               ar_hs;
  logic               wr_go;
  logic               wr_ok;
  logic               ar_oor;
  logic [SRAM_AW-1:0] e_word;
  logic               e_oor;
  logic [31:0]        e_data;
  logic [3:0]         e_strb;
  logic               e_last;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // Readies are gated by resetn so they read 0 while reset is held.
  assign idle    = resetn & (state == IDLE);
  assign awready = idle & ~aw_held;
  assign wready  = idle & ~w_held;
  // Writes win: no read while any write beat is held or offered.
  assign arready = idle & ~aw_held & ~w_held
                 & ~awvalid & ~wvalid;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // Same-edge handshakes bypass the holding registers.
  assign e_word = aw_hs ? awaddr[SRAM_AW+1:2] : aw_word;
  assign e_oor  = aw_hs ? |awaddr[31:SRAM_AW+2] : aw_oor;
  assign e_data = w_hs ? wdata : wdata_q;
  assign e_strb = w_hs ? wstrb : wstrb_q;
  assign e_last = w_hs ? wlast : wlast_q;

  assign wr_go  = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_ok  = e_last & ~e_oor;
  assign ar_oor = |araddr[31:SRAM_AW+2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_word    <= '0;
      aw_oor     <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      ar_err     <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= OKAY;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rresp      <= OKAY;
      rdata      <= '0;
      sram_en    <= 1'b0;
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_en <= 1'b0;
      sram_we <= '0;
      unique case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            aw_word <= awaddr[SRAM_AW+1:2];
            aw_oor  <= |awaddr[31:SRAM_AW+2];
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            wlast_q <= wlast;
          end
          // SRAM strobes are registered, so they are
          // loaded on the edge that enters WR/RD.
          if (wr_go) begin
            state      <= WR;
            sram_en    <= wr_ok;
            sram_we    <= wr_ok ? e_strb : 4'h0;
            sram_addr  <= e_word;
            sram_wdata <= e_data;
            bresp      <= wr_ok ? OKAY : SLVERR;
          end else if (ar_hs) begin
            state     <= RD;
            ar_err    <= ar_oor;
            sram_en   <= ~ar_oor;
            sram_addr <= araddr[SRAM_AW+1:2];
          end
        end
        WR: begin
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          bvalid  <= 1'b1;
          state   <= BRESP;
        end
        BRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        RD: begin
          state <= RCAP;
        end
        RCAP: begin
          rdata  <= ar_err ? 32'h0 : sram_rdata;
          rresp  <= ar_err ? SLVERR : OKAY;
          rvalid <= 1'b1;
          rlast  <= 1'b1;
          state  <= RRESP;
        end
        RRESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI responder that terminates single-beat AXI read/write transactions from a CPU-side initiator and drives a synchronous single-port SRAM. It is the target end of the AXI channel set the initiator drives (AW/W/B/AR/R). It serialises reads and writes through one FSM and flags protocol and address errors with SLVERR.

Parameters:
SRAM_AW, 16, SRAM word-address width; the byte range served is 0 .. 2^(SRAM_AW+2)-1.

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
awaddr  in  32  write byte address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last beat; must be 1
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  00 = OKAY, 10 = SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  32  read byte address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data, registered
rresp  out  2  00 = OKAY, 10 = SLVERR
rlast  out  1  equals rvalid
rvalid  out  1  read data valid
rready  in  1  read data ready
sram_en  out  1  SRAM access strobe
sram_we  out  4  byte write enables; 0 means read
sram_addr  out  SRAM_AW  word address = byte address [SRAM_AW+1:2]
sram_wdata  out  32  write data
sram_rdata  in  32  read data, valid the cycle after sram_en with sram_we = 0

Behaviour:
- Reset (async, resetn = 0): state IDLE; aw_held and w_held cleared. awready, wready, arready, bvalid, rvalid, rlast, sram_en = 0. sram_we = 0, bresp = 0, rresp = 0, rdata = 0, sram_addr = 0, sram_wdata = 0.
- Reset asserted mid-transaction aborts it. No response is issued afterwards, and no SRAM write occurs unless sram_en was already sampled.
- States: IDLE, WR, BRESP, RD, RCAP, RRESP.

IDLE:
- awready = ~aw_held; wready = ~w_held.
- AW and W handshakes are captured independently, in either order or in the same cycle, into address/data/strb/wlast registers.
- arready = ~aw_held & ~w_held & ~awvalid & ~wvalid. Writes have priority; a read is never accepted while any write beat is pending or offered.
- Once both AW and W are held (including via same-cycle handshakes), the next state is WR.
- On an AR handshake, latch araddr; next state is RD.

WR (1 cycle):
- If the captured wlast = 1 and awaddr[31:SRAM_AW+2] = 0: sram_en = 1, sram_we = wstrb, set bresp = 00.
- Otherwise: no SRAM access (sram_en = 0), set bresp = 10.
- Clear aw_held and w_held; next state BRESP.

BRESP:
- bvalid = 1; bresp is held stable until bready.
- On the bvalid & bready edge, go to IDLE.
- Write latency: handshake edge N, SRAM write in cycle N+1, bvalid in cycle N+2.

RD (1 cycle):
- If in range: sram_en = 1, sram_we = 0.
- If out of range: no access; mark the error.
- Next state RCAP.

RCAP (1 cycle):
- rdata <= sram_rdata if in range, else 0.
- rresp <= 00 if in range, else 10.
- Next state RRESP.

RRESP:
- rvalid = rlast = 1. rdata and rresp stay stable while rready = 0.
- On the rvalid & rready edge, go to IDLE.
- Read latency: AR handshake edge N, sram_en in N+1, rvalid in N+3.

Other rules:
- awready, wready and arready are 0 outside IDLE.
- At most one outstanding transaction at a time.
- sram_en is asserted only in WR and RD.
- Unused awaddr/araddr bits [1:0] are ignored.

Test Plan:
1. awaddr = 0x4, wdata = 0xabcdaaaa, wstrb = 0xF, wlast = 1, both valid in the same cycle, bready = 1 -> sram_we = 0xF, sram_addr = 1, sram_wdata = 0xabcdaaaa one cycle after the handshake; bvalid = 1, bresp = 00 the cycle after that.
2. Then araddr = 0x4, rready = 1 -> sram_en = 1 with sram_addr = 1 at N+1; rvalid = rlast = 1, rdata = 0xabcdaaaa, rresp = 00 at N+3.
3. W offered 3 cycles before AW at address 0x8 with wstrb = 0x3 -> wready accepts immediately; awready accepts later; only the low 2 bytes are written. A read of 0x8 shows the new low half and the old upper half.
4. awvalid, wvalid and arvalid raised in the same cycle -> arready = 0 until the write completes at bvalid & bready; the read is then accepted and returns the freshly written data.
5. rready held 0 for 4 cycles in RRESP -> rvalid stays 1 and rdata is unchanged; the FSM returns to IDLE only after the rready handshake. The same check applies to bready in BRESP.
6. Error and reset cases:
   - wlast = 0 -> bresp = 10, no SRAM write.
   - araddr = 0x40000 with SRAM_AW = 16 -> rresp = 10, rdata = 0, sram_en never asserted.
   - resetn pulsed low during RCAP -> rvalid = 0 and IDLE immediately; the next AR is accepted normally.
